// File: rtl/quad_encoder_channel.sv
// One rotary-encoder channel: sync, debounce, x1 quadrature decode and
// an up/down value register that feeds a PWM duty input.
module quad_encoder_channel #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP            = 1,
    parameter bit SATURATE        = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] value,
    output logic             step_up,
    output logic             step_dn,
    output logic             a_clean,
    output logic             b_clean
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH:0] STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] V_MAX  = '1;

    logic          a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic          a_clean_q, a_clean_d, b_clean_q, b_clean_d;
    logic          a_prev_q, b_prev_q;
    logic [WIDTH-1:0] value_q, value_d;
    logic          up_q, up_d, dn_q, dn_d;
    logic          a_rise;
    logic [WIDTH:0] sum_up, sum_dn;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1_q <= 1'b0;
            a_s2_q <= 1'b0;
            b_s1_q <= 1'b0;
            b_s2_q <= 1'b0;
        end else begin
            a_s1_q <= enc_a;
            a_s2_q <= a_s1_q;
            b_s1_q <= enc_b;
            b_s2_q <= b_s1_q;
        end
    end

    // A new level is accepted only after it has held for DEBOUNCE_CYCLES samples
    always_comb begin
        a_cnt_d   = a_cnt_q;
        a_clean_d = a_clean_q;
        if (a_s2_q == a_clean_q) begin
            a_cnt_d = '0;
        end else if (a_cnt_q == CNT_LAST) begin
            a_clean_d = a_s2_q;
            a_cnt_d   = '0;
        end else begin
            a_cnt_d = a_cnt_q + 1'b1;
        end
    end

    always_comb begin
        b_cnt_d   = b_cnt_q;
        b_clean_d = b_clean_q;
        if (b_s2_q == b_clean_q) begin
            b_cnt_d = '0;
        end else if (b_cnt_q == CNT_LAST) begin
            b_clean_d = b_s2_q;
            b_cnt_d   = '0;
        end else begin
            b_cnt_d = b_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            a_clean_q <= 1'b0;
            b_clean_q <= 1'b0;
            a_prev_q  <= 1'b0;
            b_prev_q  <= 1'b0;
        end else begin
            a_cnt_q   <= a_cnt_d;
            b_cnt_q   <= b_cnt_d;
            a_clean_q <= a_clean_d;
            b_clean_q <= b_clean_d;
            a_prev_q  <= a_clean_q;
            b_prev_q  <= b_clean_q;
        end
    end

    // x1 decode: only a rising clean A counts; B level picks the direction
    always_comb begin
        a_rise  = a_clean_q & ~a_prev_q;
        up_d    = a_rise & ~b_clean_q;
        dn_d    = a_rise & b_clean_q;
        sum_up  = {1'b0, value_q} + STEP_X;
        sum_dn  = {1'b0, value_q} - STEP_X;
        value_d = value_q;
        if (up_d) begin
            if (SATURATE && sum_up[WIDTH]) value_d = V_MAX;
            else value_d = sum_up[WIDTH-1:0];
        end else if (dn_d) begin
            if (SATURATE && sum_dn[WIDTH]) value_d = '0;
            else value_d = sum_dn[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            value_q <= value_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    // b_prev_q is kept for debug symmetry; B edges never step
    logic unused_b_prev;
    assign unused_b_prev = b_prev_q;

    assign value   = value_q;
    assign step_up = up_q;
    assign step_dn = dn_q;
    assign a_clean = a_clean_q;
    assign b_clean = b_clean_q;

endmodule

// File: tb/tb_quad_encoder_channel.sv
// Directed bench: a wrapping default channel and a saturating STEP=16
// channel driven from the same encoder pins.
module tb_quad_encoder_channel;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;

    logic [7:0] v, sv;
    logic up, dn, ac, bc;
    logic sup, sdn, sac, sbc;

    int checks = 0;
    int failures = 0;
    int up_cnt = 0, dn_cnt = 0, sup_cnt = 0, sdn_cnt = 0, both_cnt = 0;
    int b_up, b_dn, b_sup, b_sdn;

    always #5 clk = ~clk;

    quad_encoder_channel dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .value(v), .step_up(up), .step_dn(dn),
        .a_clean(ac), .b_clean(bc)
    );

    quad_encoder_channel #(.WIDTH(8), .DEBOUNCE_CYCLES(4),
                           .STEP(16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .value(sv), .step_up(sup), .step_dn(sdn),
        .a_clean(sac), .b_clean(sbc)
    );

    always @(posedge clk) begin
        if (up) up_cnt <= up_cnt + 1;
        if (dn) dn_cnt <= dn_cnt + 1;
        if (sup) sup_cnt <= sup_cnt + 1;
        if (sdn) sdn_cnt <= sdn_cnt + 1;
        if ((up && dn) || (sup && sdn)) both_cnt <= both_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_up = up_cnt; b_dn = dn_cnt; b_sup = sup_cnt; b_sdn = sdn_cnt;
    endtask

    task automatic do_step(input logic dir);
        enc_b = dir;
        cyc(8);
        enc_a = 1'b1;
        cyc(8);
        enc_a = 1'b0;
        cyc(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enc_a = 1'($urandom);
        enc_b = 1'($urandom);
        cyc(2);
        reset = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({v, up, dn, ac, bc} !== 12'h0) begin
            $display("FAIL reset_outs got=%h want=000", {v, up, dn, ac, bc});
            failures++;
        end
        checks++;
        if ({sv, sup, sdn, sac, sbc} !== 12'h0) begin
            $display("FAIL reset_outs_sat got=%h want=000", {sv, sup, sdn, sac, sbc});
            failures++;
        end
        cyc(10);
        checks++;
        if ({v, up, dn, ac, bc, sv} !== 20'h0) begin
            $display("FAIL idle_after_reset got=%h want=00000", {v, up, dn, ac, bc, sv});
            failures++;
        end
    endtask

    task automatic test_single_step();
        snap();
        enc_a = 1'b1;
        cyc(5);
        checks++;
        if (ac !== 1'b0) begin
            $display("FAIL a_clean_e5 got=%b want=0", ac);
            failures++;
        end
        cyc(1);
        checks++;
        if (ac !== 1'b1 || v !== 8'd0) begin
            $display("FAIL a_clean_e6 got=%b/%0d want=1/0", ac, v);
            failures++;
        end
        cyc(1);
        checks++;
        if (v !== 8'd1 || up !== 1'b1 || sv !== 8'd16 || sup !== 1'b1) begin
            $display("FAIL step_e7 got=%0d/%b/%0d/%b want=1/1/16/1", v, up, sv, sup);
            failures++;
        end
        cyc(1);
        checks++;
        if (up !== 1'b0 || sup !== 1'b0) begin
            $display("FAIL step_up_e8 got=%b/%b want=0/0", up, sup);
            failures++;
        end
        enc_a = 1'b0;
        cyc(8);
        do_step(1'b1);
        checks++;
        if (v !== 8'd0 || sv !== 8'd0) begin
            $display("FAIL down_step got=%0d/%0d want=0/0", v, sv);
            failures++;
        end
        checks++;
        if (dn_cnt - b_dn != 1 || sdn_cnt - b_sdn != 1 || up_cnt - b_up != 1) begin
            $display("FAIL single_pulses got=dn%0d sdn%0d up%0d want=1/1/1",
                     dn_cnt - b_dn, sdn_cnt - b_sdn, up_cnt - b_up);
            failures++;
        end
    endtask

    task automatic test_glitch();
        enc_b = 1'b0;
        cyc(8);
        snap();
        enc_a = 1'b1;
        cyc(3);
        enc_a = 1'b0;
        cyc(10);
        checks++;
        if (ac !== 1'b0 || v !== 8'd0 || up_cnt != b_up || dn_cnt != b_dn) begin
            $display("FAIL glitch3 got=ac%b v%0d up%0d want=0/0/0", ac, v, up_cnt - b_up);
            failures++;
        end
        enc_a = 1'b1;
        cyc(4);
        enc_a = 1'b0;
        cyc(10);
        checks++;
        if (v !== 8'd1 || sv !== 8'd16 || up_cnt - b_up != 1) begin
            $display("FAIL glitch4 got=%0d/%0d up%0d want=1/16/1", v, sv, up_cnt - b_up);
            failures++;
        end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        cyc(4);
        snap();
        for (int i = 0; i < 20; i++) do_step(1'b0);
        checks++;
        if (v !== 8'd20 || sv !== 8'd255) begin
            $display("FAIL up20 got=%0d/%0d want=20/255", v, sv);
            failures++;
        end
        checks++;
        if (up_cnt - b_up != 20 || sup_cnt - b_sup != 20) begin
            $display("FAIL up20_pulses got=%0d/%0d want=20/20",
                     up_cnt - b_up, sup_cnt - b_sup);
            failures++;
        end
        for (int i = 20; i < 256; i++) do_step(1'b0);
        checks++;
        if (v !== 8'd0 || sv !== 8'd255) begin
            $display("FAIL up256 got=%0d/%0d want=0/255", v, sv);
            failures++;
        end
        checks++;
        if (up_cnt - b_up != 256 || sup_cnt - b_sup != 256) begin
            $display("FAIL up256_pulses got=%0d/%0d want=256/256",
                     up_cnt - b_up, sup_cnt - b_sup);
            failures++;
        end
    endtask

    task automatic test_down_boundary();
        do_reset();
        cyc(4);
        snap();
        do_step(1'b1);
        checks++;
        if (v !== 8'd255 || sv !== 8'd0) begin
            $display("FAIL down_from0 got=%0d/%0d want=255/0", v, sv);
            failures++;
        end
        checks++;
        if (dn_cnt - b_dn != 1 || sdn_cnt - b_sdn != 1) begin
            $display("FAIL down_from0_pulses got=%0d/%0d want=1/1",
                     dn_cnt - b_dn, sdn_cnt - b_sdn);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        enc_b = 1'b0;
        cyc(8);
        snap();
        enc_a = 1'b1;
        cyc(5);
        reset = 1'b1;
        enc_a = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(12);
        checks++;
        if (v !== 8'd0 || ac !== 1'b0 || up_cnt != b_up || sv !== 8'd0) begin
            $display("FAIL reset_mid got=v%0d ac%b up%0d sv%0d want=0/0/0/0",
                     v, ac, up_cnt - b_up, sv);
            failures++;
        end
        do_step(1'b0);
        checks++;
        if (v !== 8'd1 || sv !== 8'd16 || up_cnt - b_up != 1) begin
            $display("FAIL after_reset_mid got=%0d/%0d up%0d want=1/16/1",
                     v, sv, up_cnt - b_up);
            failures++;
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt != 0) begin
            $display("FAIL up_dn_together got=%0d want=0", both_cnt);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_glitch();
        test_wrap_saturate();
        test_down_boundary();
        test_reset_mid();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
